// File: rtl/hbm_loop_ctrl_if.sv
// Command/completion channel between the loop controller and the HBM channel stage.
interface hbm_loop_ctrl_if #(
  parameter int ADDR_W = 33
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rsp_valid;
  logic              rsp_err;

  modport master (output cmd_valid, cmd_wr, cmd_addr, input  cmd_ready, rsp_valid, rsp_err);
  modport slave  (input  cmd_valid, cmd_wr, cmd_addr, output cmd_ready, rsp_valid, rsp_err);
endinterface

// File: rtl/hbm_loop_ctrl.sv
// HBM loop test controller: one write pass then one read pass of SIZE_LOOP commands,
// counting errored completions; started and aborted from a gpio control word.
module hbm_loop_ctrl #(
  parameter int SIZE_LOOP = 128,
  parameter int ADDR_W    = 33,
  parameter int ADDR_STEP = 4096
) (
  input  logic            sclk,
  input  logic            xdma_rstn,
  input  logic [31:0]     gpio,
  hbm_loop_ctrl_if.master cmd,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [15:0]     err_cnt
);

  localparam int                CNT_W = 17;
  localparam logic [CNT_W-1:0]  LOOP_N = CNT_W'(SIZE_LOOP);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(SIZE_LOOP - 1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(ADDR_STEP);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DONE, S_ABORT} state_t;

  state_t            state;
  logic [31:0]       gpio_q;
  logic              trig_q;
  logic              start_q;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  cmp_cnt;

  logic              start;
  logic [ADDR_W-1:0] page_addr;
  logic              xfer;
  logic              rsp_ok;
  logic              pass_end;
  logic              stop;

  assign start     = gpio_q[1] & ~trig_q & gpio_q[0];
  assign page_addr = ADDR_W'({gpio_q[31:16], 12'h000});
  assign xfer      = cmd.cmd_valid & cmd.cmd_ready;
  assign rsp_ok    = cmd.rsp_valid & (cmp_cnt < LOOP_N);
  assign pass_end  = rsp_ok & (cmp_cnt == LAST);
  // An offered command is never retracted: abort waits for its transfer.
  assign stop      = ~gpio_q[0] & (~cmd.cmd_valid | cmd.cmd_ready);

  always_ff @(posedge sclk or negedge xdma_rstn) begin
    if (!xdma_rstn) begin
      state         <= S_IDLE;
      gpio_q        <= '0;
      trig_q        <= 1'b0;
      start_q       <= 1'b0;
      base          <= '0;
      iss_cnt       <= '0;
      cmp_cnt       <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_wr    <= 1'b0;
      cmd.cmd_addr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err_cnt       <= '0;
    end else begin
      gpio_q  <= gpio;
      trig_q  <= gpio_q[1];
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (start_q) begin
            state         <= S_WR;
            base          <= page_addr;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_wr    <= 1'b1;
            cmd.cmd_addr  <= page_addr;
            busy          <= 1'b1;
            done          <= 1'b0;
            aborted       <= 1'b0;
            err_cnt       <= '0;
            iss_cnt       <= '0;
            cmp_cnt       <= '0;
          end
        end
        S_WR, S_RD: begin
          if (rsp_ok) begin
            cmp_cnt <= cmp_cnt + 1'b1;
            if (cmd.rsp_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end
          if (xfer) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == LAST) cmd.cmd_valid <= 1'b0;
            else                 cmd.cmd_addr  <= cmd.cmd_addr + STEP;
          end
          if (stop) begin
            state         <= S_ABORT;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_wr    <= 1'b0;
            busy          <= 1'b0;
            aborted       <= 1'b1;
          end else if (pass_end) begin
            if (state == S_WR) begin
              state         <= S_RD;
              cmd.cmd_valid <= 1'b1;
              cmd.cmd_wr    <= 1'b0;
              cmd.cmd_addr  <= base;
              iss_cnt       <= '0;
              cmp_cnt       <= '0;
            end else begin
              state         <= S_DONE;
              cmd.cmd_valid <= 1'b0;
              cmd.cmd_wr    <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end
          end
        end
        S_DONE:  if (!gpio_q[0]) state <= S_IDLE;
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbm_loop_ctrl.sv
// Directed bench: per-cycle vector table on a SIZE_LOOP=4 instance, plus address-wrap
// and err_cnt saturation sequences on two more instances.
module tb_hbm_loop_ctrl;

  logic        sclk = 1'b0;
  logic        rstn_a = 1'b0, rstn_bc = 1'b0;
  logic [31:0] gpio_a = '0, gpio_b = '0, gpio_c = '0;
  logic        busy_a, done_a, ab_a, busy_b, done_b, ab_b, busy_c, done_c, ab_c;
  logic [15:0] err_a, err_b, err_c;
  int          n_cmp = 0, n_bad = 0;

  always #5 sclk = ~sclk;

  hbm_loop_ctrl_if #(.ADDR_W(33)) if_a ();
  hbm_loop_ctrl_if #(.ADDR_W(28)) if_b ();
  hbm_loop_ctrl_if #(.ADDR_W(33)) if_c ();

  hbm_loop_ctrl #(.SIZE_LOOP(4), .ADDR_W(33), .ADDR_STEP(4096)) u_a (
    .sclk(sclk), .xdma_rstn(rstn_a), .gpio(gpio_a), .cmd(if_a),
    .busy(busy_a), .done(done_a), .aborted(ab_a), .err_cnt(err_a));
  hbm_loop_ctrl #(.SIZE_LOOP(2), .ADDR_W(28), .ADDR_STEP(4096)) u_b (
    .sclk(sclk), .xdma_rstn(rstn_bc), .gpio(gpio_b), .cmd(if_b),
    .busy(busy_b), .done(done_b), .aborted(ab_b), .err_cnt(err_b));
  hbm_loop_ctrl #(.SIZE_LOOP(32768), .ADDR_W(33), .ADDR_STEP(4096)) u_c (
    .sclk(sclk), .xdma_rstn(rstn_bc), .gpio(gpio_c), .cmd(if_c),
    .busy(busy_c), .done(done_c), .aborted(ab_c), .err_cnt(err_c));

  // Responders for B and C complete each command in its transfer cycle.
  assign if_b.rsp_valid = if_b.cmd_valid & if_b.cmd_ready;
  assign if_b.rsp_err   = 1'b0;
  assign if_c.rsp_valid = if_c.cmd_valid & if_c.cmd_ready;
  assign if_c.rsp_err   = 1'b1;

  logic [28:0] b_log[$];
  always @(posedge sclk) if (if_b.cmd_valid && if_b.cmd_ready) b_log.push_back({if_b.cmd_wr, if_b.cmd_addr});

  typedef struct {
    logic        rst;
    logic [31:0] gpio;
    logic        rdy, rv, re;
    logic        cv, wr;
    logic [32:0] addr;
    logic        busy, done, ab;
    logic [15:0] err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic [31:0] g, logic rdy, logic rv, logic re,
                              logic cv, logic wr, logic [32:0] addr,
                              logic bz, logic dn, logic ab, logic [15:0] err);
    vec_t v;
    v.rst = rst; v.gpio = g; v.rdy = rdy; v.rv = rv; v.re = re;
    v.cv = cv; v.wr = wr; v.addr = addr; v.busy = bz; v.done = dn; v.ab = ab; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] P2 = 32'h0002_0000;
  localparam logic [31:0] P7 = 32'h0007_0000;

  initial begin
    logic [28:0] b_exp [4];
    b_exp[0] = {1'b1, 28'hFFFF000}; b_exp[1] = {1'b1, 28'h0000000};
    b_exp[2] = {1'b0, 28'hFFFF000}; b_exp[3] = {1'b0, 28'h0000000};

    // run 1: full write+read pass, errors on two completions
    add(0, P2|3, 0,0,0, 0,0,0,       0,0,0, 0);
    add(0, P2|1, 0,0,0, 0,0,0,       0,0,0, 0);
    add(0, P2|1, 0,0,0, 1,1,'h2000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P2|1, 1,1,1, 1,1,'h4000,  1,0,0, 1);
    add(0, P2|1, 1,1,0, 1,1,'h5000,  1,0,0, 1);
    add(0, P2|1, 1,1,0, 1,0,'h2000,  1,0,0, 1);
    add(0, P2|1, 1,1,0, 1,0,'h3000,  1,0,0, 1);
    add(0, P2|1, 1,1,1, 1,0,'h4000,  1,0,0, 2);
    add(0, P2|1, 1,1,0, 1,0,'h5000,  1,0,0, 2);
    add(0, P2|1, 1,1,0, 0,0,0,       0,1,0, 2);
    add(0, P2|1, 0,0,0, 0,0,0,       0,1,0, 2);
    add(0, P2,   0,0,0, 0,0,0,       0,1,0, 2);
    add(0, P2,   0,0,0, 0,0,0,       0,1,0, 2);
    // run 2: stall on second write, ignored retrigger and page change, then abort
    add(0, P2|3, 0,0,0, 0,0,0,       0,1,0, 2);
    add(0, P2|1, 0,0,0, 0,0,0,       0,1,0, 2);
    add(0, P2|1, 0,0,0, 1,1,'h2000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P7|3, 0,0,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P7|1, 0,0,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P7|1, 0,0,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P7|1, 1,1,0, 1,1,'h4000,  1,0,0, 0);
    add(0, P7,   0,0,0, 1,1,'h4000,  1,0,0, 0);
    add(0, P7,   0,0,0, 1,1,'h4000,  1,0,0, 0);
    add(0, P7,   1,1,0, 0,0,0,       0,0,1, 0);
    add(0, P7,   0,0,0, 0,0,0,       0,0,1, 0);
    // run 3: into the read pass, reset, restart from base
    add(0, P2|3, 0,0,0, 0,0,0,       0,0,1, 0);
    add(0, P2|1, 0,0,0, 0,0,0,       0,0,1, 0);
    add(0, P2|1, 0,0,0, 1,1,'h2000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h4000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h5000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,0,'h2000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,0,'h3000,  1,0,0, 0);
    add(1, P2|3, 1,1,0, 0,0,0,       0,0,0, 0);
    add(0, P2|3, 0,0,0, 0,0,0,       0,0,0, 0);
    add(0, P2|1, 0,0,0, 0,0,0,       0,0,0, 0);
    add(0, P2|1, 0,0,0, 1,1,'h2000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h3000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h4000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,1,'h5000,  1,0,0, 0);
    add(0, P2|1, 1,1,0, 1,0,'h2000,  1,0,0, 0);

    if_a.cmd_ready = 0; if_a.rsp_valid = 0; if_a.rsp_err = 0;
    if_b.cmd_ready = 1; if_c.cmd_ready = 1;
    repeat (3) @(posedge sclk);
    #1;
    chk("reset_a", {if_a.cmd_valid, if_a.cmd_wr, if_a.cmd_addr, busy_a, done_a, ab_a, err_a},
        64'h0);
    rstn_a = 1; rstn_bc = 1;

    foreach (tbl[i]) begin
      rstn_a = ~tbl[i].rst;
      gpio_a = tbl[i].gpio;
      if_a.cmd_ready = tbl[i].rdy; if_a.rsp_valid = tbl[i].rv; if_a.rsp_err = tbl[i].re;
      @(posedge sclk); #1;
      chk($sformatf("row%0d.ctl{cv,wr,busy,done,ab}", i),
          {if_a.cmd_valid, if_a.cmd_wr, busy_a, done_a, ab_a},
          {tbl[i].cv, tbl[i].wr, tbl[i].busy, tbl[i].done, tbl[i].ab});
      chk($sformatf("row%0d.err_cnt", i), err_a, tbl[i].err);
      if (tbl[i].cv) chk($sformatf("row%0d.cmd_addr", i), if_a.cmd_addr, tbl[i].addr);
    end

    // reset mid-read takes effect without a clock edge and stays quiet afterwards
    if_a.cmd_ready = 0; if_a.rsp_valid = 0;
    #2 rstn_a = 0;
    #1 chk("async_reset", {if_a.cmd_valid, if_a.cmd_wr, if_a.cmd_addr, busy_a, done_a, ab_a, err_a},
           64'h0);
    @(posedge sclk); #1 rstn_a = 1;
    repeat (5) @(posedge sclk);
    #1 chk("no_cmd_after_reset", {if_a.cmd_valid, busy_a}, 64'h0);

    // address wrap on a 28-bit bus
    gpio_b = 32'hFFFF_0003;
    @(posedge sclk); #1 gpio_b = 32'hFFFF_0001;
    for (int i = 0; i < 50 && !done_b; i++) @(posedge sclk);
    #1 chk("wrap_done", done_b, 1'b1);
    chk("wrap_count", b_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < b_log.size()) chk($sformatf("wrap_cmd%0d{wr,addr}", i), b_log[i], b_exp[i]);

    // every completion errored, 65536 of them in total
    gpio_c = 32'h0001_0003;
    @(posedge sclk); #1 gpio_c = 32'h0001_0001;
    for (int i = 0; i < 70000 && !done_c; i++) @(posedge sclk);
    #1 chk("sat_done", done_c, 1'b1);
    chk("sat_err_cnt", err_c, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
